// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampled, start + DATA_BITS data (LSB first) + 1 stop.
// Emits one-cycle done / framing-error pulses and holds the last correctly received byte.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done_tick,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    // A divider of zero would never tick; treat it as tick-every-cycle.
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [2:0]       N_LAST   = 3'(DATA_BITS - 1);
    localparam logic [3:0]       S_MID    = 4'd7;
    localparam logic [3:0]       S_LAST   = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // Free-running 16x baud tick.
    logic [DIV_W-1:0] tick_cnt_q;
    logic             s_tick;

    assign s_tick = (tick_cnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else if (s_tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    state_e               state_q, state_d;
    logic [3:0]           s_cnt_q, s_cnt_d;
    logic [2:0]           n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        n_cnt_d   = n_cnt_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Edge-triggered, so a line stuck low cannot start another frame.
                if (rx_fall) begin
                    state_d = StStart;
                    s_cnt_d = '0;
                end
            end

            StStart: begin
                if (s_tick) begin
                    if (s_cnt_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = StData;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end

            StData: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                        s_cnt_d = '0;
                        if (n_cnt_q == N_LAST) begin
                            state_d = StStop;
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end

            StStop: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        if (rx_s_q) begin
                            rx_data_d = 8'(shreg_q);
                            done_d    = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = StIdle;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = done_q;
    assign rx_frame_err = err_q;
    assign rx_busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame (range 5..8).
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port rx  input  1  asynchronous serial line, idle high, 8N1 framing (start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity).
REQ-007 Port rx_data  output  8  last correctly received byte; unused upper bits zero when DATA_BITS<8.
REQ-008 Port rx_done_tick  output  1  one-cycle pulse: new valid byte on rx_data.
REQ-009 Port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port rx_busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value (rx_s) and its one-cycle-delayed copy.
REQ-012 Oversampling tick generator: DIV = CLK_FREQ/(BAUD_RATE*16), integer division; free-running counter 0..DIV-1; s_tick high for one clk when counter = DIV-1, then counter wraps to 0.
REQ-013 FSM states: IDLE, START, DATA, STOP; 4-bit tick counter s_cnt, 3-bit bit counter n_cnt, DATA_BITS-wide shift register.
REQ-014 IDLE: on falling edge of rx_s (previous 1, current 0) -> START, s_cnt <= 0; a line held low SHALL NOT retrigger.
REQ-015 START: s_cnt increments on each s_tick; on the s_tick where s_cnt = 7 (mid start bit): rx_s = 0 -> DATA, s_cnt <= 0, n_cnt <= 0; rx_s = 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: on the s_tick where s_cnt = 15, sample rx_s into shift register MSB (shift right), s_cnt <= 0; when n_cnt = DATA_BITS-1 -> STOP, else n_cnt increments.
REQ-017 STOP: on the s_tick where s_cnt = 15, sample rx_s; 1 -> rx_data <= shift register (right-aligned), rx_done_tick pulse; 0 -> rx_frame_err pulse, rx_data unchanged; both -> IDLE.
REQ-018 rx_done_tick and rx_frame_err SHALL be registered, asserted in the clk cycle immediately after the stop-bit sampling tick, for exactly one clk, never simultaneously.
REQ-019 rx_data SHALL hold its value until the next valid frame completes.
REQ-020 A new start edge SHALL be accepted as soon as the FSM is back in IDLE (back-to-back frames with zero idle time).
REQ-021 Frame latency: rx_done_tick SHALL occur 16*(DATA_BITS+1)+8 s_tick periods (+/-1 tick period, +3 clk synchronizer/edge delay) after the rx falling edge.

Reset
REQ-022 While reset is high at a clk edge: state <= IDLE, s_cnt, n_cnt, shift register, tick counter <= 0, synchronizer flops <= 1, rx_data <= 0x00, rx_done_tick <= 0, rx_frame_err <= 0, rx_busy <= 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no pulse on any output; the following frame SHALL be received only from its own start edge.

Verification (CLK_FREQ=1_600_000, BAUD_RATE=10_000 -> DIV=10, 160 clk per bit)
REQ-024 Drive frame 0x35 -> one rx_done_tick, rx_data=0x35, rx_frame_err never high, rx_busy high for the frame then low.
REQ-025 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_done_ticks, rx_data=0x00 then 0xFF.
REQ-026 rx low for 40 clk then high -> no pulses, FSM returns to IDLE; subsequent 0x5A received correctly.
REQ-027 Frame 0xA5 with stop bit forced 0 -> one rx_frame_err pulse, no rx_done_tick, rx_data keeps previous value.
REQ-028 reset pulsed during bit 3 of 0x12, then frame 0x41 -> no pulse for the aborted frame, rx_done_tick with rx_data=0x41.
REQ-029 rx held low 5000 clk (break) then released -> exactly one rx_frame_err pulse, no further pulses until the next falling edge.
